// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the writeback stage entry record.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int ADDR_W = 3;

  // Bit positions inside the {N,Z,C,V} status and flag-mask vectors
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              n;
    logic              z;
    logic              c;
    logic              v;
    logic [ADDR_W-1:0] dst;
    logic              reg_we;
    logic [3:0]        flag_we;
    logic              zchain;
  } wb_entry_t;

endpackage

// File: rtl/alu_writeback_stage_if.sv
// ALU-to-writeback result handshake: the ALU is master, the writeback stage is slave.
interface alu_writeback_stage_if;
  import cpu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_sum;
  logic              in_c;
  logic              in_n;
  logic              in_z;
  logic              in_v;
  logic [ADDR_W-1:0] in_dst;
  logic              in_reg_we;
  logic [3:0]        in_flag_we;
  logic              in_zchain;

  modport master (
    output in_valid, in_sum, in_c, in_n, in_z, in_v,
           in_dst, in_reg_we, in_flag_we, in_zchain,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_sum, in_c, in_n, in_z, in_v,
           in_dst, in_reg_we, in_flag_we, in_zchain,
    output in_ready
  );

endinterface

// File: rtl/regfile_2r1w.sv
// General register file: one write port, two combinational read ports, R0 hardwired to zero.
module regfile_2r1w
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [NREGS];

  // Writes to R0 are dropped here so callers need not filter them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/alu_writeback_stage.sv
// One-entry pipeline register between the ALU and the register file / status flags,
// with operand bypass and carry feedback so dependent ops issue without bubbles.
module alu_writeback_stage
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  alu_writeback_stage_if.slave alu,
  input  logic                 wb_hold,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [DATA_W-1:0]    rd_data_a,
  output logic [DATA_W-1:0]    rd_data_b,
  output logic [3:0]           status,
  output logic                 carry_out
);

  wb_entry_t         stage_q;
  wb_entry_t         incoming;
  logic              stage_valid;
  logic              accept;
  logic              commit;
  logic [3:0]        status_d;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;

  assign alu.in_ready = !stage_valid || !wb_hold;
  assign accept       = alu.in_valid && alu.in_ready;
  assign commit       = stage_valid && !wb_hold;

  assign incoming = '{sum: alu.in_sum, n: alu.in_n, z: alu.in_z, c: alu.in_c, v: alu.in_v,
                      dst: alu.in_dst, reg_we: alu.in_reg_we, flag_we: alu.in_flag_we,
                      zchain: alu.in_zchain};

  // Commit and accept may share an edge, giving one result per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_q     <= '0;
      status      <= '0;
    end else begin
      if (accept) stage_q <= incoming;
      if (accept)      stage_valid <= 1'b1;
      else if (commit) stage_valid <= 1'b0;
      if (commit) status <= status_d;
    end
  end

  // Z chaining lets a multi-word compare AND the per-word zero results together
  always_comb begin
    status_d = status;
    if (stage_q.flag_we[FLAG_N]) status_d[FLAG_N] = stage_q.n;
    if (stage_q.flag_we[FLAG_Z])
      status_d[FLAG_Z] = stage_q.zchain ? (stage_q.z & status[FLAG_Z]) : stage_q.z;
    if (stage_q.flag_we[FLAG_C]) status_d[FLAG_C] = stage_q.c;
    if (stage_q.flag_we[FLAG_V]) status_d[FLAG_V] = stage_q.v;
  end

  regfile_2r1w u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (commit && stage_q.reg_we),
    .waddr   (stage_q.dst),
    .wdata   (stage_q.sum),
    .raddr_a (rd_addr_a),
    .raddr_b (rd_addr_b),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  always_comb begin
    rd_data_a = rf_a;
    if (rd_addr_a == '0)
      rd_data_a = '0;
    else if (stage_valid && stage_q.reg_we && (rd_addr_a == stage_q.dst))
      rd_data_a = stage_q.sum;
  end

  always_comb begin
    rd_data_b = rf_b;
    if (rd_addr_b == '0)
      rd_data_b = '0;
    else if (stage_valid && stage_q.reg_we && (rd_addr_b == stage_q.dst))
      rd_data_b = stage_q.sum;
  end

  assign carry_out = (stage_valid && stage_q.flag_we[FLAG_C]) ? stage_q.c : status[FLAG_C];

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed plus randomized checks of the writeback stage against a behavioural
// model of the register file, status flags and the single pending result.
module tb_alu_writeback_stage;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wb_hold = 1'b0;
  logic [ADDR_W-1:0] rd_addr_a = '0;
  logic [ADDR_W-1:0] rd_addr_b = '0;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [3:0]        status;
  logic              carry_out;

  alu_writeback_stage_if alu ();

  alu_writeback_stage dut (
    .clk       (clk),
    .rst       (rst),
    .alu       (alu.slave),
    .wb_hold   (wb_hold),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .status    (status),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] sum;
    logic [ADDR_W-1:0] dst;
    bit                we;
    bit [3:0]          fwe;
    bit                n, z, c, v, zc;
  } op_t;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Reference state: architectural registers, flags, and at most one pending op
  logic [DATA_W-1:0] m_regs [NREGS];
  bit                m_n, m_z, m_c, m_v;
  bit                m_pend;
  op_t               m_op;
  bit                cur_valid;
  op_t               cur_op;

  function automatic op_t mkop(logic [DATA_W-1:0] sum, logic [ADDR_W-1:0] dst, bit we,
                               bit [3:0] fwe, bit n, bit z, bit c, bit v, bit zc);
    op_t o;
    o.sum = sum; o.dst = dst; o.we = we; o.fwe = fwe;
    o.n = n; o.z = z; o.c = c; o.v = v; o.zc = zc;
    return o;
  endfunction

  function automatic logic [DATA_W-1:0] modelRead(logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
    if (m_pend && m_op.we && m_op.dst == a) return m_op.sum;
    return m_regs[a];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    {m_n, m_z, m_c, m_v} = 4'b0000;
    m_pend = 1'b0;
  endtask

  task automatic checkValue(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(string tag);
    checkValue({tag, "/ready"}, 32'(alu.in_ready), 32'(!m_pend || !wb_hold));
    checkValue({tag, "/rda"}, 32'(rd_data_a), 32'(modelRead(rd_addr_a)));
    checkValue({tag, "/rdb"}, 32'(rd_data_b), 32'(modelRead(rd_addr_b)));
    checkValue({tag, "/status"}, 32'(status), 32'({m_n, m_z, m_c, m_v}));
    checkValue({tag, "/carry"}, 32'(carry_out),
               32'((m_pend && m_op.fwe[1]) ? m_op.c : m_c));
  endtask

  task automatic applyStimulus(bit valid, op_t op, bit hold);
    cur_valid      = valid;
    cur_op         = op;
    alu.in_valid   = valid;
    alu.in_sum     = op.sum;
    alu.in_dst     = op.dst;
    alu.in_reg_we  = op.we;
    alu.in_flag_we = op.fwe;
    alu.in_n       = op.n;
    alu.in_z       = op.z;
    alu.in_c       = op.c;
    alu.in_v       = op.v;
    alu.in_zchain  = op.zc;
    wb_hold        = hold;
    #1;
  endtask

  // Advance one clock edge and apply the accept/commit rules to the model
  task automatic stepClock();
    bit  acc;
    bit  com;
    op_t nw;
    acc = cur_valid && (!m_pend || !wb_hold);
    com = m_pend && !wb_hold;
    nw  = cur_op;
    @(posedge clk);
    if (com) begin
      if (m_op.we && m_op.dst != 0) m_regs[m_op.dst] = m_op.sum;
      if (m_op.fwe[3]) m_n = m_op.n;
      if (m_op.fwe[2]) m_z = m_op.zc ? (m_op.z && m_z) : m_op.z;
      if (m_op.fwe[1]) m_c = m_op.c;
      if (m_op.fwe[0]) m_v = m_op.v;
    end
    if (acc) begin
      m_op   = nw;
      m_pend = 1'b1;
    end else if (com) begin
      m_pend = 1'b0;
    end
    #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    op_t idle;
    op_t rop;
    bit  rvalid;
    bit  rhold;
    bit  keep;
    idle = mkop('0, '0, 0, 4'h0, 0, 0, 0, 0, 0);
    modelReset();
    applyStimulus(0, idle, 0);
    rd_addr_a = 3'd1;
    rd_addr_b = 3'd2;

    #1 rst = 1'b1;
    #1;
    checkValue("rst_ready", 32'(alu.in_ready), 32'd1);
    checkValue("rst_status", 32'(status), 32'd0);
    checkValue("rst_carry", 32'(carry_out), 32'd0);
    checkValue("rst_rda", 32'(rd_data_a), 32'd0);
    #10 rst = 1'b0;

    // Basic write of the ALU result 0x1111 + 0x2222
    applyStimulus(1, mkop(16'h3333, 3'd1, 1, 4'hF, 0, 0, 0, 0, 0), 0);
    checkOutput("basic_pre");
    stepClock();
    applyStimulus(0, idle, 0);
    checkValue("basic_bypass", 32'(rd_data_a), 32'h3333);
    checkOutput("basic_pend");
    stepClock();
    applyStimulus(0, idle, 0);
    checkValue("basic_rf", 32'(rd_data_a), 32'h3333);
    checkValue("basic_status", 32'(status), 32'h0);

    // Back-to-back carry chain
    applyStimulus(1, mkop(16'h2221, 3'd1, 1, 4'hF, 0, 0, 1, 0, 0), 0);
    stepClock();
    applyStimulus(1, mkop(16'h0001, 3'd2, 1, 4'hF, 0, 0, 0, 0, 0), 0);
    checkValue("chain_carry1", 32'(carry_out), 32'd1);
    checkValue("chain_rda", 32'(rd_data_a), 32'h2221);
    checkOutput("chain_op1");
    stepClock();
    applyStimulus(0, idle, 0);
    checkValue("chain_carry2", 32'(carry_out), 32'd0);
    checkValue("chain_status1", 32'(status), 32'b0010);
    stepClock();
    applyStimulus(0, idle, 0);
    checkValue("chain_r2", 32'(rd_data_b), 32'h0001);
    checkValue("chain_status2", 32'(status), 32'b0000);
    checkOutput("chain_done");

    // Hold freezes the stage; the upstream keeps presenting its next op
    rd_addr_a = 3'd4;
    rd_addr_b = 3'd5;
    applyStimulus(1, mkop(16'h4444, 3'd4, 1, 4'b1000, 1, 0, 0, 0, 0), 0);
    stepClock();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, mkop(16'h7777, 3'd5, 1, 4'hF, 0, 1, 1, 1, 0), 1);
      checkValue("hold_ready", 32'(alu.in_ready), 32'd0);
      checkValue("hold_status", 32'(status), 32'b0000);
      checkValue("hold_rdb", 32'(rd_data_b), 32'h0);
      checkOutput("hold");
      stepClock();
    end
    applyStimulus(1, mkop(16'h7777, 3'd5, 1, 4'hF, 0, 1, 1, 1, 0), 0);
    checkValue("release_ready", 32'(alu.in_ready), 32'd1);
    stepClock();
    applyStimulus(0, idle, 0);
    checkValue("release_status", 32'(status), 32'b1000);
    checkValue("release_r4", 32'(rd_data_a), 32'h4444);
    checkValue("release_bypass5", 32'(rd_data_b), 32'h7777);
    stepClock();
    applyStimulus(0, idle, 0);
    checkValue("second_status", 32'(status), 32'b0111);
    checkOutput("release_done");

    // R0 writes are dropped; Z chaining
    rd_addr_a = 3'd0;
    applyStimulus(1, mkop(16'hAAAA, 3'd0, 1, 4'hF, 0, 1, 0, 0, 0), 0);
    stepClock();
    applyStimulus(1, mkop(16'h0000, 3'd6, 0, 4'hF, 0, 0, 0, 0, 1), 0);
    checkValue("r0_bypass", 32'(rd_data_a), 32'h0);
    stepClock();
    applyStimulus(1, mkop(16'h0000, 3'd6, 0, 4'hF, 0, 1, 0, 0, 1), 0);
    checkValue("r0_zset", 32'(status), 32'b0100);
    stepClock();
    applyStimulus(0, idle, 0);
    checkValue("zchain_clear", 32'(status), 32'b0000);
    stepClock();
    applyStimulus(0, idle, 0);
    checkValue("zchain_keep", 32'(status), 32'b0000);
    checkOutput("zchain_done");

    // Asynchronous reset while a result is pending
    rd_addr_a = 3'd3;
    applyStimulus(1, mkop(16'h5555, 3'd3, 1, 4'hF, 1, 1, 1, 1, 0), 0);
    stepClock();
    applyStimulus(0, idle, 1);
    checkValue("midrst_bypass", 32'(rd_data_a), 32'h5555);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkValue("midrst_ready", 32'(alu.in_ready), 32'd1);
    checkValue("midrst_status", 32'(status), 32'd0);
    checkValue("midrst_rda", 32'(rd_data_a), 32'd0);
    checkValue("midrst_carry", 32'(carry_out), 32'd0);
    #3 rst = 1'b0;
    applyStimulus(0, idle, 0);
    stepClock();
    stepClock();
    applyStimulus(0, idle, 0);
    checkValue("midrst_r3", 32'(rd_data_a), 32'd0);
    checkValue("midrst_status2", 32'(status), 32'd0);
    checkOutput("midrst_done");

    // Randomized traffic; a stalled op is re-presented unchanged
    rvalid = 1'b0;
    rop    = idle;
    keep   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!keep) begin
        rvalid = ($urandom_range(0, 3) != 0);
        rop = mkop(DATA_W'($urandom), ADDR_W'($urandom_range(0, NREGS - 1)),
                   bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 1)));
      end
      rhold     = ($urandom_range(0, 3) == 0);
      rd_addr_a = ADDR_W'($urandom_range(0, NREGS - 1));
      rd_addr_b = ADDR_W'($urandom_range(0, NREGS - 1));
      applyStimulus(rvalid, rop, rhold);
      checkOutput("rand");
      keep = rvalid && !(!m_pend || !rhold);
      stepClock();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Downstream stage of the 16-bit ALU in the full CPU.
- Captures the ALU `sum` and NZCV flags into a one-entry pipeline register. On the next cycle it commits them to an 8 x 16 register file and the status register.
- Feeds the committed or pending carry back to the ALU `cin` for multi-word arithmetic.
- Provides two bypassed read ports that supply the ALU `A`/`B` operands.

Parameters:
- DATA_W, 16, datapath width; must match the ALU.
- NREGS, 8, number of general registers.
- ADDR_W, 3, register address width; equals log2(NREGS).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU result present.
- in_ready  out  1  stage can accept a result this cycle.
- in_sum  in  DATA_W  ALU sum.
- in_c, in_n, in_z, in_v  in  1 each  ALU flags.
- in_dst  in  ADDR_W  destination register.
- in_reg_we  in  1  write sum to in_dst.
- in_flag_we  in  4  per-flag update mask, bit order {N,Z,C,V}.
- in_zchain  in  1  Z becomes in_z AND old Z, for multi-word compare.
- wb_hold  in  1  downstream stall; freezes commit.
- rd_addr_a, rd_addr_b  in  ADDR_W  read addresses.
- rd_data_a, rd_data_b  out  DATA_W  read data, combinational.
- status  out  4  committed {N,Z,C,V}.
- carry_out  out  1  carry for the ALU cin.

Behaviour:
- Reset, asynchronous and active-high:
  - Register file, status and the pipeline register are all cleared; stage_valid=0.
  - Outputs during reset: in_ready=1, status=0, carry_out=0, rd_data=0.
  - A pending result at reset time is discarded, never committed.
- Accept: a result is accepted at edge T when in_valid && in_ready. It then occupies the stage and sets stage_valid.
- Commit:
  - Occurs at the first edge after T with wb_hold=0.
  - Register write occurs if reg_we=1 and dst!=0.
  - Each flag updates only where its flag_we bit is set.
  - If zchain=1 and the Z mask bit is set, Z_new = stage_z & Z_old. Otherwise Z_new = stage_z.
  - stage_valid clears unless a new result is accepted on the same edge.
- in_ready = !stage_valid || !wb_hold.
  - Simultaneous commit and accept is legal, giving one result per cycle throughput.
- Hold: with stage_valid=1 and wb_hold=1, the stage contents are frozen and in_ready=0. in_valid is ignored, and the upstream must hold its data.
- R0: reads as 0; writes to it are silently dropped. Flags from such an op still commit per mask.
- Reads are combinational, priority highest first:
  1. addr==0 returns 0.
  2. stage_valid && stage_reg_we && addr==stage_dst returns stage_sum (bypass).
  3. Otherwise the register file content.
- carry_out = (stage_valid && stage_flag_we[C]) ? stage_c : status C.
  - This allows back-to-back chained adds without a bubble.
- Width: no arithmetic in this block; values are stored verbatim.
- Latency:
  - Result to register file/status: 1 cycle after accept when not held.
  - Result to read port and carry_out: 0 cycles after accept, via bypass.

Decomposition:
- Shared package `cpu_pkg`:
  - DATA_W, NREGS, ADDR_W.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module `regfile_2r1w`: NREGS x DATA_W storage with async reset, one write port, two combinational read ports, and R0 forced to 0. Bypass and flag logic stay in the top.

Test Plan:
- Basic write: accept sum=0x1111 (see note), dst=1, reg_we=1, flag_we=4'hF, c=0,n=0,z=0,v=0. Next cycle rd_addr_a=1 gives 0x1111; one cycle later status=4'b0000.
  - Note: the value is arbitrary. Make it the ALU output for 0x1111+0x2222 = 0x3333, then expect 0x3333 throughout.
- Carry chain:
  - Op 1: sum=0x2221, c=1, flag_we=4'hF. In the same cycle as the accept, carry_out=1 via bypass.
  - Op 2: back-to-back, sum=0x0001, dst=2. Both commit; R2=0x0001; final status C equals op-2 c.
- Hold: stage_valid=1 and wb_hold=1 for 3 cycles gives in_ready=0, with R and status unchanged. Releasing the hold commits exactly once.
- R0 and zchain:
  - Write 0xAAAA to dst=0 with z=1. rd_addr_a=0 gives 0; Z=1.
  - Next op: z=0, zchain=1 gives Z=0.
  - Then op z=1, zchain=1 keeps Z=0.
- Reset mid-op: assert rst while stage_valid=1 with sum=0x5555, dst=3. R3 stays 0; status=0; in_ready=1 immediately.
